// File: rtl/riscv_run_pkg.sv
// Shared encodings for the RISC-V run controller: status codes, FSM states and
// the default tohost address.
package riscv_run_pkg;

    localparam logic [2:0] ST_RUNNING = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_HALT    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StDone
    } run_state_t;

endpackage

// File: rtl/riscv_halt_det.sv
// Jump-to-self detector: flags the PC match that completes HALT_REPEAT
// consecutive equal-PC comparisons while enabled.
module riscv_halt_det #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear,
    input  logic            enable,
    input  logic [XLEN-1:0] pc,
    output logic            halt
);

    localparam int unsigned RW = $clog2(HALT_REPEAT + 1);
    localparam logic [RW-1:0] RepMax = RW'(HALT_REPEAT);

    logic [XLEN-1:0] prev_pc;
    logic            prev_valid;
    logic [RW-1:0]   rep_cnt;
    logic            match;

    assign match = enable && prev_valid && (pc == prev_pc);
    // Pulse on the match that brings the count to HALT_REPEAT.
    assign halt  = match && (rep_cnt >= RepMax - RW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            rep_cnt    <= '0;
        end else if (clear) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            rep_cnt    <= '0;
        end else if (enable) begin
            prev_pc    <= pc;
            prev_valid <= 1'b1;
            if (!match) begin
                rep_cnt <= '0;
            end else if (rep_cnt < RepMax) begin
                rep_cnt <= rep_cnt + RW'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: releases the core from reset, counts RUN cycles and latches
// a sticky PASS/FAIL/HALT/TIMEOUT status when the program ends.
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      CNT_W       = 32,
    parameter int unsigned      RST_CYCLES  = 2,
    parameter int unsigned      MAX_CYCLES  = 25,
    parameter int unsigned      HALT_REPEAT = 4,
    parameter logic [XLEN-1:0]  TOHOST_ADDR = XLEN'(DEFAULT_TOHOST_ADDR)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             mem_we_i,
    input  logic [XLEN-1:0]  mem_addr_i,
    input  logic [XLEN-1:0]  mem_wd_i,
    output logic             core_rst_o,
    output logic             done_o,
    output logic [2:0]       status_o,
    output logic [XLEN-1:0]  fail_code_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam int unsigned HW = $clog2(RST_CYCLES + 1);
    localparam logic [HW-1:0]    HoldLast = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(MAX_CYCLES - 1);

    run_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic          halt;
    logic          tohost;
    logic          timeout;

    riscv_halt_det #(
        .XLEN        (XLEN),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_det (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (state == StHold),
        .enable (state == StRun),
        .pc     (pc_i),
        .halt   (halt)
    );

    assign tohost  = mem_we_i && (mem_addr_i == TOHOST_ADDR);
    assign timeout = (cycle_cnt_o == CntLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= StHold;
            hold_cnt    <= '0;
            core_rst_o  <= 1'b1;
            done_o      <= 1'b0;
            status_o    <= ST_RUNNING;
            fail_code_o <= '0;
            cycle_cnt_o <= '0;
        end else begin
            unique case (state)
                StHold: begin
                    if (hold_cnt == HoldLast) begin
                        core_rst_o <= 1'b0;
                        state      <= StRun;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                StRun: begin
                    cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
                    // Priority: tohost store, then self-loop, then budget.
                    if (tohost) begin
                        state  <= StDone;
                        done_o <= 1'b1;
                        if (mem_wd_i == XLEN'(1)) begin
                            status_o <= ST_PASS;
                        end else begin
                            status_o    <= ST_FAIL;
                            fail_code_o <= mem_wd_i >> 1;
                        end
                    end else if (halt) begin
                        state    <= StDone;
                        done_o   <= 1'b1;
                        status_o <= ST_HALT;
                    end else if (timeout) begin
                        state    <= StDone;
                        done_o   <= 1'b1;
                        status_o <= ST_TIMEOUT;
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: begin
                    state <= StHold;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: reset release, PASS/FAIL/HALT/TIMEOUT,
// event priority and asynchronous reset out of DONE.
module tb_riscv_run_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        core_rst;
    logic        done;
    logic [2:0]  status;
    logic [31:0] fail_code;
    logic [31:0] cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_run_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pc_i        (pc),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wd_i    (mem_wd),
        .core_rst_o  (core_rst),
        .done_o      (done),
        .status_o    (status),
        .fail_code_o (fail_code),
        .cycle_cnt_o (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_we   = 1'b0;
        mem_addr = 32'h0;
        mem_wd   = 32'h0;
    endtask

    // Reset, release, and wait out the two hold edges; leaves the FSM in RUN.
    task automatic start_run();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_we   = 1'b1;
        mem_addr = addr;
        mem_wd   = data;
    endtask

    initial begin
        rst = 1'b1;
        pc  = 32'h0;
        idle_inputs();
        #2;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);

        // Release with a tohost PASS store pending during HOLD; it must be ignored.
        tick();
        rst = 1'b0;
        store(32'h1000, 32'h1);
        tick();
        chk("hold_edge1_core_rst", core_rst, 1);
        tick();
        chk("hold_edge2_core_rst", core_rst, 0);
        chk("hold_store_ignored", done, 0);
        chk("hold_cnt_zero", cycle_cnt, 0);
        idle_inputs();

        // PASS in RUN cycle 7.
        for (int i = 1; i <= 6; i++) begin
            pc = 32'h100 + 32'(i) * 4;
            tick();
            chk($sformatf("run_cnt_%0d", i), cycle_cnt, 64'(i));
        end
        chk("run_not_done", done, 0);
        pc = 32'h200;
        store(32'h1000, 32'h1);
        tick();
        chk("pass_done", done, 1);
        chk("pass_status", status, 1);
        chk("pass_cnt", cycle_cnt, 7);
        chk("pass_code", fail_code, 0);
        store(32'h1000, 32'h6);
        pc = 32'h200;
        for (int i = 0; i < 10; i++) tick();
        chk("frozen_done", done, 1);
        chk("frozen_status", status, 1);
        chk("frozen_cnt", cycle_cnt, 7);
        chk("frozen_code", fail_code, 0);
        chk("frozen_core_rst", core_rst, 0);

        // Async reset out of DONE, checked before any clock edge.
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("async_core_rst", core_rst, 1);
        chk("async_status", status, 0);
        chk("async_done", done, 0);
        chk("async_cnt", cycle_cnt, 0);

        // FAIL with code.
        start_run();
        pc = 32'h0;
        store(32'h1000, 32'h7);
        tick();
        chk("fail7_status", status, 2);
        chk("fail7_code", fail_code, 3);
        chk("fail7_cnt", cycle_cnt, 1);

        // FAIL with zero write.
        start_run();
        pc = 32'h0;
        tick();
        store(32'h1000, 32'h0);
        tick();
        chk("fail0_status", status, 2);
        chk("fail0_code", fail_code, 0);
        chk("fail0_done", done, 1);

        // Store to a different address is not tohost.
        start_run();
        pc = 32'h40;
        store(32'h1004, 32'h1);
        tick();
        chk("other_addr_done", done, 0);
        idle_inputs();

        // HALT: 0,4,8,8,8,8,8 halts on the last PC (4th consecutive match).
        start_run();
        pc = 32'h0; tick();
        pc = 32'h4; tick();
        for (int i = 0; i < 4; i++) begin
            pc = 32'h8;
            tick();
        end
        chk("halt_pre_done", done, 0);
        pc = 32'h8;
        tick();
        chk("halt_status", status, 3);
        chk("halt_cnt", cycle_cnt, 7);

        // No halt: 8,8,8,C,8.
        start_run();
        pc = 32'h8; tick();
        pc = 32'h8; tick();
        pc = 32'h8; tick();
        pc = 32'hC; tick();
        pc = 32'h8; tick();
        chk("nohalt_done", done, 0);
        chk("nohalt_status", status, 0);

        // TIMEOUT after 25 RUN cycles.
        start_run();
        for (int i = 1; i <= 24; i++) begin
            pc = 32'h300 + 32'(i) * 4;
            tick();
        end
        chk("to_pre_done", done, 0);
        pc = 32'h500;
        tick();
        chk("to_status", status, 4);
        chk("to_cnt", cycle_cnt, 25);

        // Tohost store in cycle 25 beats TIMEOUT.
        start_run();
        for (int i = 1; i <= 24; i++) begin
            pc = 32'h300 + 32'(i) * 4;
            tick();
        end
        pc = 32'h500;
        store(32'h1000, 32'h1);
        tick();
        chk("prio_to_status", status, 1);
        chk("prio_to_cnt", cycle_cnt, 25);

        // Tohost store coinciding with the halting match beats HALT.
        start_run();
        for (int i = 0; i < 4; i++) begin
            pc = 32'h8;
            tick();
        end
        pc = 32'h8;
        store(32'h1000, 32'h5);
        tick();
        chk("prio_halt_status", status, 2);
        chk("prio_halt_code", fail_code, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
